alu_mc: RTL and testbench
=========================

# alu_mc

Parametrised multi-cycle ALU for the MIPS datapath. It keeps the existing 3-bit logic/add/subtract operation set and its carry/overflow semantics, and adds signed and unsigned set-less-than plus an iterative unsigned multiply that writes a double-width HI/LO result. Operands enter and results leave through valid/ready handshakes with a registered output, so the EX stage can stall on a multiply without special-casing.

## Interface
- `WIDTH`, default 32: operand width; must be ≥ 2.
- `MUL_EN`, default 1: 0 removes multiply hardware; `MULTU` then executes as reserved.
- `clk`  in  1  clock; rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands and op are presented.
- `in_ready`  out  1  block can accept; combinational, `= (state != MUL) && (!out_valid || out_ready)`.
- `a`, `b`  in  WIDTH  operands.
- `op`  in  4  operation code.
- `cin`  in  1  carry-in for `ADD`/`SUB`.
- `out_valid`  out  1  result registers hold a result.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  WIDTH  low result word.
- `result_hi`  out  WIDTH  high word; 0 except for `MULTU`.
- `cout`  out  1  carry out of MSB for `ADD`/`SUB`, else 0.
- `v`  out  1  signed overflow for `ADD`/`SUB`, else 0.
- `busy`  out  1  high while in `MUL`.

## Operation
- Op codes: 0000 XOR, 0001 XNOR, 0010 ADD (`a+b+cin`), 0011 SUB (`a+~b+cin`; the caller drives `cin=1` for a true subtract), 0100 OR, 0101 NOR, 0110 AND, 1000 MULTU, 1001 SLT (signed), 1010 SLTU. All other codes are reserved: result 0, flags 0, latency 1.
- `v` = carry into MSB XOR carry out of MSB, the same as the existing adder.
- SLT/SLTU compute `a+~b+1` with `cin` ignored. SLT result = sign XOR overflow. SLTU result = NOT carry out. The bit is zero-extended to WIDTH, and `cout`/`v` are 0.
- A transfer occurs when `in_valid && in_ready` on a rising edge.
- FSM states:
  - IDLE: no result pending.
  - MUL: iterating.
  - DONE: `out_valid` = 1.
- Transitions:
  - IDLE or DONE, on accepting a non-MULTU op: go to DONE and register the result.
  - IDLE or DONE, on accepting MULTU: go to MUL. Load `acc = {carry 0, WIDTH'0, b}`, `mcand = a`, `cnt = WIDTH`, and clear `out_valid`.
  - MUL, each edge: if `acc[0]` is set, add `mcand` into the upper half with its carry. Then shift `acc` right by 1 and decrement `cnt`. When `cnt` reaches 0 on that edge, go to DONE with `{result_hi, result} = acc[2W-1:0]`.
  - DONE, on `out_ready` with no new accept: go to IDLE and clear `out_valid`. Result registers hold their last value.
  - DONE, on `out_ready` together with an accept: the result is handed over and the new op is taken in the same edge.
- Output registers are stable while `out_valid && !out_ready`.
- Reset, including mid-multiply: state goes to IDLE and any in-flight op is discarded with no result produced.
  - `out_valid`, `result`, `result_hi`, `cout`, `v`, `busy` = 0.
  - `cnt`, `acc`, `mcand` = 0.
  - `in_ready` = 1 while `rst_n` is deasserted.

## Timing
- Single-cycle ops: latency 1. `out_valid` rises on the edge that accepts the op. Back-to-back issue at 1 op per cycle is possible when `out_ready` = 1.
- MULTU: `out_valid` rises exactly WIDTH edges after the accepting edge. `in_ready` = 0 for those WIDTH cycles. Throughput is 1 per WIDTH+1 cycles under continuous `out_ready`.
- No combinational path from `a`/`b`/`op` to any output. The only combinational path from an input to an output is `out_ready` → `in_ready`.
- `cnt` is `$clog2(WIDTH+1)` bits wide. The accumulator is 2·WIDTH+1 bits.

## Structure
- Shared package `alu_pkg`: op-code localparams (`OP_XOR` … `OP_SLTU`), FSM state encoding, and the op-width constant.
- Sub-module `alu_comb #(WIDTH)`: combinational single-cycle datapath producing result, `cout`, and `v` for all non-multiply ops. It is built from the existing lookahead-carry style, generalised to WIDTH.
- `alu_mc` contains the FSM, handshake logic, multiply iterator, and output registers.

## Test plan
- ADD `a=0xFFFFFFFF`, `b=0x00000001`, `cin=0` → one cycle later `result=0x00000000`, `cout=1`, `v=0`, `result_hi=0`.
- SUB `a=0x80000000`, `b=0x00000001`, `cin=1` → `result=0x7FFFFFFF`, `cout=1`, `v=1`. SLT with `a=0xFFFFFFFF`, `b=0x00000001` → `result=1`; SLTU with the same operands → `result=0`.
- MULTU `a=0xFFFFFFFF`, `b=0xFFFFFFFF` → `busy`=1 and `in_ready`=0 for 32 cycles, then `out_valid` = 1 exactly 32 edges after accept with `result_hi=0xFFFFFFFE`, `result=0x00000001`. MULTU `7×6` → `result=42`, `result_hi=0`.
- Backpressure: issue AND `0xF0F0F0F0 & 0x0FF00FF0` with `out_ready=0` for 5 cycles → `result=0x00F000F0` held stable and `in_ready=0`. Raise `out_ready` with a new XOR valid on the same edge → both transfers occur in that edge.
- Reset mid-multiply: drop `rst_n` at iteration 10 → all outputs 0 immediately. After release, an ADD `2+3` → `result=5` with latency 1 and no stale multiply result.
- Reserved op 0111 and MULTU with `MUL_EN=0` → `result=0`, `result_hi=0`, `cout=0`, `v=0`, latency 1; repeat the ADD case at `WIDTH=8` (`0xFF+0x01` → 0, `cout=1`).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and op width for the multi-cycle ALU.
package alu_pkg;

   localparam int unsigned OP_W = 4;

   localparam logic [OP_W-1:0] OP_XOR   = 4'b0000;
   localparam logic [OP_W-1:0] OP_XNOR  = 4'b0001;
   localparam logic [OP_W-1:0] OP_ADD   = 4'b0010;
   localparam logic [OP_W-1:0] OP_SUB   = 4'b0011;
   localparam logic [OP_W-1:0] OP_OR    = 4'b0100;
   localparam logic [OP_W-1:0] OP_NOR   = 4'b0101;
   localparam logic [OP_W-1:0] OP_AND   = 4'b0110;
   localparam logic [OP_W-1:0] OP_MULTU = 4'b1000;
   localparam logic [OP_W-1:0] OP_SLT   = 4'b1001;
   localparam logic [OP_W-1:0] OP_SLTU  = 4'b1010;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StMul  = 2'd1,
      StDone = 2'd2
   } state_t;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle datapath: logic ops, add/subtract with carry/overflow, and set-less-than.
module alu_comb
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OP_W-1:0]  op,
   input  logic             cin,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             v
);

   logic             inv_b;
   logic             c_in;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] gen;
   logic [WIDTH-1:0] prop;
   logic [WIDTH-1:0] sum;
   logic [WIDTH:0]   carry;

   // Generate/propagate carry chain; compares force a true subtract regardless of cin.
   always_comb begin
      inv_b = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
      c_in  = ((op == OP_SLT) || (op == OP_SLTU)) ? 1'b1 : cin;
      b_eff = inv_b ? ~b : b;
      gen   = a & b_eff;
      prop  = a ^ b_eff;
      carry = '0;
      carry[0] = c_in;
      for (int i = 0; i < WIDTH; i++) begin
         carry[i+1] = gen[i] | (prop[i] & carry[i]);
      end
      sum = prop ^ carry[WIDTH-1:0];
   end

   always_comb begin
      result = '0;
      cout   = 1'b0;
      v      = 1'b0;
      case (op)
         OP_XOR:  result = a ^ b;
         OP_XNOR: result = ~(a ^ b);
         OP_OR:   result = a | b;
         OP_NOR:  result = ~(a | b);
         OP_AND:  result = a & b;
         OP_ADD, OP_SUB: begin
            result = sum;
            cout   = carry[WIDTH];
            v      = carry[WIDTH] ^ carry[WIDTH-1];
         end
         OP_SLT:  result[0] = sum[WIDTH-1] ^ carry[WIDTH] ^ carry[WIDTH-1];
         OP_SLTU: result[0] = ~carry[WIDTH];
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: handshaked front end, registered results, iterative unsigned multiply.
module alu_mc
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter bit          MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OP_W-1:0]  op,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             cout,
   output logic             v,
   output logic             busy
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [2*WIDTH:0]   acc_q;
   logic [WIDTH-1:0]   mcand_q;

   logic [WIDTH-1:0]   comb_result;
   logic               comb_cout;
   logic               comb_v;
   logic               accept;
   logic               is_mul;
   logic [WIDTH:0]     upper;
   logic [2*WIDTH:0]   acc_step;

   alu_comb #(
      .WIDTH(WIDTH)
   ) u_comb (
      .a      (a),
      .b      (b),
      .op     (op),
      .cin    (cin),
      .result (comb_result),
      .cout   (comb_cout),
      .v      (comb_v)
   );

   assign in_ready = (state_q != StMul) && (!out_valid || out_ready);

   // One shift-add step: conditional add into the upper half, then shift the carry down.
   always_comb begin
      accept   = in_valid && in_ready;
      is_mul   = MUL_EN && (op == OP_MULTU);
      upper    = acc_q[2*WIDTH:WIDTH] + {1'b0, (acc_q[0] ? mcand_q : {WIDTH{1'b0}})};
      acc_step = {1'b0, upper, acc_q[WIDTH-1:1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         acc_q     <= '0;
         mcand_q   <= '0;
         out_valid <= 1'b0;
         result    <= '0;
         result_hi <= '0;
         cout      <= 1'b0;
         v         <= 1'b0;
         busy      <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               if (accept) begin
                  if (is_mul) begin
                     state_q   <= StMul;
                     acc_q     <= {1'b0, {WIDTH{1'b0}}, b};
                     mcand_q   <= a;
                     cnt_q     <= CNT_W'(WIDTH);
                     out_valid <= 1'b0;
                     busy      <= 1'b1;
                  end else begin
                     state_q   <= StDone;
                     result    <= comb_result;
                     result_hi <= '0;
                     cout      <= comb_cout;
                     v         <= comb_v;
                     out_valid <= 1'b1;
                  end
               end else if ((state_q == StDone) && out_ready) begin
                  state_q   <= StIdle;
                  out_valid <= 1'b0;
               end
            end
            StMul: begin
               acc_q <= acc_step;
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_q   <= StDone;
                  result    <= acc_step[WIDTH-1:0];
                  result_hi <= acc_step[2*WIDTH-1:WIDTH];
                  cout      <= 1'b0;
                  v         <= 1'b0;
                  out_valid <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: arithmetic reference model with a per-cycle scoreboard, plus literal checks.
module tb_alu_mc;

   localparam logic [3:0] OP_XOR   = 4'b0000;
   localparam logic [3:0] OP_XNOR  = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_SUB   = 4'b0011;
   localparam logic [3:0] OP_OR    = 4'b0100;
   localparam logic [3:0] OP_NOR   = 4'b0101;
   localparam logic [3:0] OP_AND   = 4'b0110;
   localparam logic [3:0] OP_RSVD  = 4'b0111;
   localparam logic [3:0] OP_MULTU = 4'b1000;
   localparam logic [3:0] OP_SLT   = 4'b1001;
   localparam logic [3:0] OP_SLTU  = 4'b1010;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, cin, out_valid, out_ready, cout, v, busy;
   logic [31:0] a, b, result, result_hi;
   logic [3:0]  op;

   logic        in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, v8, busy8;
   logic [7:0]  a8, b8, result8, result_hi8;
   logic [3:0]  op8;

   int checks = 0;
   int errors = 0;
   int unsigned cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_mc #(.WIDTH(32), .MUL_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .op(op), .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .result_hi(result_hi), .cout(cout), .v(v), .busy(busy)
   );

   alu_mc #(.WIDTH(8), .MUL_EN(1'b0)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
      .op(op8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8), .result(result8),
      .result_hi(result_hi8), .cout(cout8), .v(v8), .busy(busy8)
   );

   typedef struct packed {
      logic [31:0] lo;
      logic [31:0] hi;
      logic        c;
      logic        ov;
      logic        mul;
      int unsigned due;
   } exp_t;

   exp_t q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference behaviour from plain arithmetic on the operands.
   function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                  input logic ci);
      exp_t        e;
      logic [32:0] s;
      logic [63:0] p;
      e = '0;
      case (o)
         OP_XOR:  e.lo = x ^ y;
         OP_XNOR: e.lo = ~(x ^ y);
         OP_OR:   e.lo = x | y;
         OP_NOR:  e.lo = ~(x | y);
         OP_AND:  e.lo = x & y;
         OP_ADD: begin
            s = {1'b0, x} + {1'b0, y} + {32'd0, ci};
            e.lo = s[31:0];
            e.c  = s[32];
            e.ov = (x[31] == y[31]) && (s[31] != x[31]);
         end
         OP_SUB: begin
            s = {1'b0, x} + {1'b0, ~y} + {32'd0, ci};
            e.lo = s[31:0];
            e.c  = s[32];
            e.ov = (x[31] != y[31]) && (s[31] != x[31]);
         end
         OP_MULTU: begin
            p = {32'd0, x} * {32'd0, y};
            e.lo  = p[31:0];
            e.hi  = p[63:32];
            e.mul = 1'b1;
         end
         OP_SLT:  e.lo = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         OP_SLTU: e.lo = (x < y) ? 32'd1 : 32'd0;
         default: e = '0;
      endcase
      return e;
   endfunction

   // Per-cycle scoreboard against the model's view of outstanding work.
   initial begin
      logic exp_valid, exp_busy, exp_rdy;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
            chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
            chk("rst_outputs", {result_hi, result}, 64'd0);
            chk("rst_flags", {61'd0, cout, v, busy}, 64'd0);
            q.delete();
         end else begin
            exp_valid = (q.size() > 0) && (cyc >= q[0].due);
            exp_busy  = (q.size() > 0) && q[0].mul && (cyc < q[0].due);
            exp_rdy   = !exp_busy && (!exp_valid || out_ready);
            chk("sb_out_valid", {63'd0, out_valid}, {63'd0, exp_valid});
            chk("sb_busy", {63'd0, busy}, {63'd0, exp_busy});
            chk("sb_in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
            if (exp_valid && out_valid) begin
               chk("sb_result", {result_hi, result}, {q[0].hi, q[0].lo});
               chk("sb_flags", {62'd0, cout, v}, {62'd0, q[0].c, q[0].ov});
            end
            if (exp_valid && out_ready) void'(q.pop_front());
            if (in_valid && exp_rdy) begin
               e = model(op, a, b, cin);
               e.due = cyc + 1 + (e.mul ? 32 : 0);
               q.push_back(e);
            end
         end
      end
   end

   task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic ci);
      logic ok;
      @(posedge clk);
      #1;
      in_valid = 1'b1; op = o; a = x; b = y; cin = ci;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      chk("issue_accept", {63'd0, ok}, 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_res(input string name, input logic [31:0] lo, input logic [31:0] hi,
                           input logic c, input logic ov);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) begin
            seen = 1'b1;
            break;
         end
      end
      chk({name, "_seen"}, {63'd0, seen}, 64'd1);
      chk({name, "_res"}, {result_hi, result}, {hi, lo});
      chk({name, "_flags"}, {62'd0, cout, v}, {62'd0, c, ov});
   endtask

   task automatic wait_mul(input string name, input logic [31:0] lo, input logic [31:0] hi);
      int n;
      logic seen;
      n = 0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) begin
            seen = 1'b1;
            break;
         end
         if (busy && !in_ready) n++;
      end
      chk({name, "_seen"}, {63'd0, seen}, 64'd1);
      chk({name, "_busy_cycles"}, 64'(n), 64'd32);
      chk({name, "_res"}, {result_hi, result}, {hi, lo});
   endtask

   logic [3:0]  vop [10];
   logic [31:0] va  [10];
   logic [31:0] vb  [10];
   logic        vc  [10];

   initial begin
      vop[0] = OP_XNOR; va[0] = 32'h0F0F0F0F; vb[0] = 32'h00FF00FF; vc[0] = 1'b0;
      vop[1] = OP_OR;   va[1] = 32'h12340000; vb[1] = 32'h00005678; vc[1] = 1'b0;
      vop[2] = OP_NOR;  va[2] = 32'h00000000; vb[2] = 32'h00000000; vc[2] = 1'b0;
      vop[3] = OP_SUB;  va[3] = 32'd5;        vb[3] = 32'd7;        vc[3] = 1'b1;
      vop[4] = OP_SUB;  va[4] = 32'd7;        vb[4] = 32'd5;        vc[4] = 1'b0;
      vop[5] = OP_ADD;  va[5] = 32'h7FFFFFFF; vb[5] = 32'd1;        vc[5] = 1'b0;
      vop[6] = OP_SLT;  va[6] = 32'd1;        vb[6] = 32'hFFFFFFFF; vc[6] = 1'b0;
      vop[7] = OP_SLTU; va[7] = 32'd1;        vb[7] = 32'hFFFFFFFF; vc[7] = 1'b1;
      vop[8] = OP_SLT;  va[8] = 32'h80000000; vb[8] = 32'h7FFFFFFF; vc[8] = 1'b0;
      vop[9] = 4'b1111; va[9] = 32'hDEADBEEF; vb[9] = 32'h12345678; vc[9] = 1'b1;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; a = '0; b = '0; op = '0; cin = 1'b0; out_ready = 1'b1;
      in_valid8 = 1'b0; a8 = '0; b8 = '0; op8 = '0; cin8 = 1'b0; out_ready8 = 1'b1;
      #1;
      chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;

      issue(OP_ADD, 32'hFFFFFFFF, 32'h00000001, 1'b0);
      wait_res("add_wrap", 32'h00000000, 32'h0, 1'b1, 1'b0);
      issue(OP_SUB, 32'h80000000, 32'h00000001, 1'b1);
      wait_res("sub_ovf", 32'h7FFFFFFF, 32'h0, 1'b1, 1'b1);
      issue(OP_SLT, 32'hFFFFFFFF, 32'h00000001, 1'b0);
      wait_res("slt_neg", 32'd1, 32'h0, 1'b0, 1'b0);
      issue(OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 1'b0);
      wait_res("sltu_big", 32'd0, 32'h0, 1'b0, 1'b0);
      issue(OP_RSVD, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
      wait_res("reserved", 32'd0, 32'h0, 1'b0, 1'b0);

      issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      wait_mul("mul_max", 32'h00000001, 32'hFFFFFFFE);
      issue(OP_MULTU, 32'd7, 32'd6, 1'b0);
      wait_mul("mul_7x6", 32'd42, 32'd0);

      // Back-to-back burst, one op per cycle, checked by the scoreboard.
      @(posedge clk);
      for (int i = 0; i < 10; i++) begin
         #1;
         in_valid = 1'b1; op = vop[i]; a = va[i]; b = vb[i]; cin = vc[i];
         @(posedge clk);
      end
      #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);

      // Backpressure: result held while consumer stalls, then swap on one edge.
      #1 out_ready = 1'b0;
      issue(OP_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold_res", {32'd0, result}, {32'd0, 32'h00F000F0});
         chk("bp_hold_ctl", {62'd0, out_valid, in_ready}, {62'd0, 1'b1, 1'b0});
      end
      @(posedge clk);
      #1;
      in_valid = 1'b1; op = OP_XOR; a = 32'hAAAA5555; b = 32'hFFFF0000; cin = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_swap_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk("bp_swap_res", {31'd0, out_valid, result}, {31'd0, 1'b1, 32'h55555555});

      // Reset part-way through a multiply.
      issue(OP_MULTU, 32'h12345678, 32'h9ABCDEF0, 1'b0);
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_outputs", {result_hi, result}, 64'd0);
      chk("midrst_ctl", {60'd0, out_valid, busy, cout, v}, 64'd0);
      chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
      @(negedge clk);
      #2 rst_n = 1'b1;
      issue(OP_ADD, 32'd2, 32'd3, 1'b0);
      wait_res("post_rst_add", 32'd5, 32'd0, 1'b0, 1'b0);
      repeat (40) @(negedge clk);
      chk("no_stale_mul", {63'd0, out_valid}, 64'd0);

      // WIDTH=8 instance with the multiplier removed.
      @(posedge clk);
      #1;
      in_valid8 = 1'b1; op8 = OP_MULTU; a8 = 8'd5; b8 = 8'd3; cin8 = 1'b0;
      @(negedge clk);
      chk("w8_ready", {63'd0, in_ready8}, 64'd1);
      @(posedge clk);
      #1;
      op8 = OP_ADD; a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0;
      @(negedge clk);
      chk("w8_mul_rsvd", {out_valid8, busy8, cout8, v8, result_hi8, result8},
          {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
      @(posedge clk);
      #1 in_valid8 = 1'b0;
      @(negedge clk);
      chk("w8_add_wrap", {out_valid8, cout8, v8, result_hi8, result8},
          {1'b1, 1'b1, 1'b0, 8'h00, 8'h00});

      repeat (3) @(negedge clk);
      chk("sb_drained", 64'(q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
